// File: rtl/alu_seq_pkg.sv
// Shared types and BCD correction constants for the ALU sequencer.
package alu_seq_pkg;

    typedef enum logic [2:0] {
        OP_ADC = 3'd0,
        OP_SBC = 3'd1,
        OP_AND = 3'd2,
        OP_ORA = 3'd3,
        OP_EOR = 3'd4,
        OP_LSR = 3'd5,
        OP_ROR = 3'd6,
        OP_CMP = 3'd7
    } op_e;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        ADJ  = 2'd2,
        DONE = 2'd3
    } state_e;

    localparam logic [7:0] BCD_LO_ADD = 8'h06;
    localparam logic [7:0] BCD_HI_ADD = 8'h60;
    localparam logic [7:0] BCD_LO_SUB = 8'hFA;
    localparam logic [7:0] BCD_HI_SUB = 8'hA0;

endpackage

// File: rtl/bcd_correct.sv
// Decimal-adjust correction term and carry from a binary ADC/SBC result.
module bcd_correct
    import alu_seq_pkg::*;
(
    input  logic [7:0] res,
    input  logic       hc,
    input  logic       c,
    input  logic       is_sub,
    output logic [7:0] corr,
    output logic       c_out
);

    logic       over_99;
    logic [7:0] lo;
    logic [7:0] hi;

    always_comb begin
        over_99 = (res > 8'h99);
        lo      = ((res[3:0] > 4'd9) || hc) ? BCD_LO_ADD : 8'h00;
        hi      = (over_99 || c) ? BCD_HI_ADD : 8'h00;
        if (is_sub) begin
            // Subtract corrections are applied as additions, wrapping mod 256.
            corr  = (hc ? 8'h00 : BCD_LO_SUB) + (c ? 8'h00 : BCD_HI_SUB);
            c_out = c;
        end else begin
            corr  = lo | hi;
            c_out = c | over_99;
        end
    end

endmodule

// File: rtl/alu_sequencer.sv
// Initiator for the 8-bit ALU: accepts one op, drives the ALU, returns result and flags.
// Optional BCD adjust pass is built when DECIMAL_MODE_EN is defined.
//
// state | meaning
// IDLE  | op_ready high, waiting for op_valid
// EXEC  | ALU driven from registered operands, result captured at end
// ADJ   | ALU adds BCD correction to the binary result (decimal build only)
// DONE  | res_valid held with stable res_* until res_ready
module alu_sequencer
    import alu_seq_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic       op_valid,
    output logic       op_ready,
    input  logic [2:0] op_code,
    input  logic [7:0] op_a,
    input  logic [7:0] op_b,
    input  logic       p_c,
    input  logic       p_d,
    output logic [7:0] alu_a,
    output logic [7:0] alu_b,
    output logic       alu_sum_sel,
    output logic       alu_and_sel,
    output logic       alu_xor_sel,
    output logic       alu_or_sel,
    output logic       alu_shr_sel,
    output logic       alu_carry_in,
    input  logic [7:0] alu_out,
    input  logic       alu_overflow,
    input  logic       alu_carry,
    input  logic       alu_half_carry,
    output logic       res_valid,
    input  logic       res_ready,
    output logic [7:0] res_data,
    output logic       res_n,
    output logic       res_z,
    output logic       res_c,
    output logic       res_v,
    output logic       res_a_we,
    output logic       res_v_we
);

    state_e     state;
    op_e        op_q;
    logic       c_q;
    logic       a0_q;
    logic       go_adj;
    logic [7:0] corr;
    logic       bcd_c;

`ifdef DECIMAL_MODE_EN
    logic dec_q;

    assign go_adj = dec_q && ((op_q == OP_ADC) || (op_q == OP_SBC));

    bcd_correct u_bcd (
        .res    (alu_out),
        .hc     (alu_half_carry),
        .c      (alu_carry),
        .is_sub (op_q == OP_SBC),
        .corr   (corr),
        .c_out  (bcd_c)
    );
`else
    logic unused_dec;

    assign go_adj     = 1'b0;
    assign corr       = 8'h00;
    assign bcd_c      = 1'b0;
    assign unused_dec = ^{p_d, alu_half_carry};
`endif

    assign op_ready = (state == IDLE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= IDLE;
            op_q         <= OP_ADC;
            c_q          <= 1'b0;
            a0_q         <= 1'b0;
`ifdef DECIMAL_MODE_EN
            dec_q        <= 1'b0;
`endif
            alu_a        <= 8'h00;
            alu_b        <= 8'h00;
            alu_sum_sel  <= 1'b0;
            alu_and_sel  <= 1'b0;
            alu_xor_sel  <= 1'b0;
            alu_or_sel   <= 1'b0;
            alu_shr_sel  <= 1'b0;
            alu_carry_in <= 1'b0;
            res_valid    <= 1'b0;
            res_data     <= 8'h00;
            res_n        <= 1'b0;
            res_z        <= 1'b0;
            res_c        <= 1'b0;
            res_v        <= 1'b0;
            res_a_we     <= 1'b0;
            res_v_we     <= 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (op_valid) begin
                        op_q  <= op_e'(op_code);
                        c_q   <= p_c;
                        a0_q  <= op_a[0];
`ifdef DECIMAL_MODE_EN
                        dec_q <= p_d;
`endif
                        // ALU drive is registered here so it is valid for the whole EXEC cycle.
                        alu_a        <= op_a;
                        alu_b        <= op_b;
                        alu_carry_in <= 1'b0;
                        unique case (op_e'(op_code))
                            OP_ADC: begin
                                alu_sum_sel  <= 1'b1;
                                alu_carry_in <= p_c;
                            end
                            OP_SBC: begin
                                alu_sum_sel  <= 1'b1;
                                alu_b        <= ~op_b;
                                alu_carry_in <= p_c;
                            end
                            OP_CMP: begin
                                alu_sum_sel  <= 1'b1;
                                alu_b        <= ~op_b;
                                alu_carry_in <= 1'b1;
                            end
                            OP_AND: alu_and_sel <= 1'b1;
                            OP_ORA: alu_or_sel  <= 1'b1;
                            OP_EOR: alu_xor_sel <= 1'b1;
                            OP_LSR: begin
                                alu_shr_sel <= 1'b1;
                                alu_b       <= 8'h00;
                            end
                            OP_ROR: begin
                                alu_shr_sel  <= 1'b1;
                                alu_b        <= 8'h00;
                                alu_carry_in <= p_c;
                            end
                        endcase
                        state <= EXEC;
                    end
                end
                EXEC: begin
                    res_data <= alu_out;
                    res_n    <= alu_out[7];
                    res_z    <= (alu_out == 8'h00);
                    res_a_we <= (op_q != OP_CMP);
                    res_v_we <= (op_q == OP_ADC) || (op_q == OP_SBC);
                    unique case (op_q)
                        OP_ADC, OP_SBC, OP_CMP: begin
                            res_c <= alu_carry;
                            res_v <= alu_overflow;
                        end
                        OP_LSR, OP_ROR: begin
                            res_c <= a0_q;
                            res_v <= 1'b0;
                        end
                        default: begin
                            res_c <= c_q;
                            res_v <= 1'b0;
                        end
                    endcase
                    alu_and_sel  <= 1'b0;
                    alu_xor_sel  <= 1'b0;
                    alu_or_sel   <= 1'b0;
                    alu_shr_sel  <= 1'b0;
                    alu_carry_in <= 1'b0;
                    if (go_adj) begin
                        alu_sum_sel <= 1'b1;
                        alu_a       <= alu_out;
                        alu_b       <= corr;
                        res_c       <= bcd_c;
                        state       <= ADJ;
                    end else begin
                        alu_sum_sel <= 1'b0;
                        alu_a       <= 8'h00;
                        alu_b       <= 8'h00;
                        res_valid   <= 1'b1;
                        state       <= DONE;
                    end
                end
                ADJ: begin
                    // Only the data is adjusted; N/Z/V keep the binary EXEC values.
                    res_data    <= alu_out;
                    alu_sum_sel <= 1'b0;
                    alu_a       <= 8'h00;
                    alu_b       <= 8'h00;
                    res_valid   <= 1'b1;
                    state       <= DONE;
                end
                DONE: begin
                    if (res_ready) begin
                        res_valid <= 1'b0;
                        state     <= IDLE;
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_alu_sequencer.sv
// Self-checking bench for alu_sequencer: behavioural ALU, reference model with
// per-cycle compare, and directed vectors with literal expectations.
module tb_alu_sequencer;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       op_valid;
    logic       op_ready;
    logic [2:0] op_code;
    logic [7:0] op_a, op_b;
    logic       p_c, p_d;
    logic [7:0] alu_a, alu_b;
    logic       alu_sum_sel, alu_and_sel, alu_xor_sel, alu_or_sel, alu_shr_sel;
    logic       alu_carry_in;
    logic [7:0] alu_out;
    logic       alu_overflow, alu_carry, alu_half_carry;
    logic       res_valid, res_ready;
    logic [7:0] res_data;
    logic       res_n, res_z, res_c, res_v, res_a_we, res_v_we;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    alu_sequencer dut (
        .clk(clk), .rst_n(rst_n),
        .op_valid(op_valid), .op_ready(op_ready), .op_code(op_code),
        .op_a(op_a), .op_b(op_b), .p_c(p_c), .p_d(p_d),
        .alu_a(alu_a), .alu_b(alu_b),
        .alu_sum_sel(alu_sum_sel), .alu_and_sel(alu_and_sel), .alu_xor_sel(alu_xor_sel),
        .alu_or_sel(alu_or_sel), .alu_shr_sel(alu_shr_sel), .alu_carry_in(alu_carry_in),
        .alu_out(alu_out), .alu_overflow(alu_overflow), .alu_carry(alu_carry),
        .alu_half_carry(alu_half_carry),
        .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data),
        .res_n(res_n), .res_z(res_z), .res_c(res_c), .res_v(res_v),
        .res_a_we(res_a_we), .res_v_we(res_v_we)
    );

    // Behavioural ALU; shifter reports no carry so the DUT must form C itself.
    logic [8:0] s9;
    logic [4:0] h5;
    always_comb begin
        s9 = {1'b0, alu_a} + {1'b0, alu_b} + {8'h00, alu_carry_in};
        h5 = {1'b0, alu_a[3:0]} + {1'b0, alu_b[3:0]} + {4'h0, alu_carry_in};
        alu_out = 8'h00;
        alu_carry = 1'b0;
        alu_overflow = 1'b0;
        alu_half_carry = 1'b0;
        if (alu_sum_sel) begin
            alu_out        = s9[7:0];
            alu_carry      = s9[8];
            alu_overflow   = (alu_a[7] == alu_b[7]) && (s9[7] != alu_a[7]);
            alu_half_carry = h5[4];
        end else if (alu_and_sel) alu_out = alu_a & alu_b;
        else if (alu_or_sel)      alu_out = alu_a | alu_b;
        else if (alu_xor_sel)     alu_out = alu_a ^ alu_b;
        else if (alu_shr_sel)     alu_out = {alu_carry_in, alu_a[7:1]};
    end

    typedef struct packed {
        logic [7:0] data;
        logic n, z, c, v, awe, vwe, adj;
    } exp_t;

    function automatic exp_t model(input logic [2:0] op, input logic [7:0] a, b,
                                   input logic c, d);
        exp_t e;
        int s, bb, ci, bin, corr;
        logic hc;
        e = '0;
        e.c = c;
        e.awe = (op != 3'd7);
        e.vwe = (op == 3'd0) || (op == 3'd1);
        case (op)
            3'd0, 3'd1, 3'd7: begin
                bb  = (op == 3'd0) ? int'(b) : 255 - int'(b);
                ci  = (op == 3'd7) ? 1 : int'(c);
                s   = int'(a) + bb + ci;
                bin = s % 256;
                e.data = 8'(bin);
                e.c = (s > 255);
                e.v = (a[7] == bb[7]) && (e.data[7] != a[7]);
                hc  = ((int'(a) % 16) + (bb % 16) + ci) > 15;
                corr = 0;
                if (d && op != 3'd7) begin
                    e.adj = 1'b0;
`ifdef DECIMAL_MODE_EN
                    e.adj = 1'b1;
`endif
                end
                if (e.adj && op == 3'd0) begin
                    corr = (((bin % 16) > 9) || hc) ? 'h06 : 0;
                    corr = corr + (((bin > 'h99) || e.c) ? 'h60 : 0);
                    e.c = e.c || (bin > 'h99);
                end else if (e.adj) begin
                    corr = (hc ? 0 : 'hFA) + (e.c ? 0 : 'hA0);
                end
                e.n = e.data[7];
                e.z = (e.data == 8'h00);
                e.data = 8'((bin + corr) % 256);
                return e;
            end
            3'd2: e.data = a & b;
            3'd3: e.data = a | b;
            3'd4: e.data = a ^ b;
            3'd5: begin e.data = a >> 1;      e.c = a[0]; end
            default: begin e.data = {c, a[7:1]}; e.c = a[0]; end
        endcase
        e.n = e.data[7];
        e.z = (e.data == 8'h00);
        return e;
    endfunction

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h at %0t", name, got, exp, $time);
        end
    endtask

    // Reference timing: busy from accept, valid after 1 (binary) or 2 (decimal) more edges.
    logic m_busy, m_valid;
    int   m_cnt;
    exp_t m_exp;
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_busy <= 1'b0; m_valid <= 1'b0; m_cnt <= 0;
        end else if (!m_busy) begin
            if (op_valid) begin
                m_busy <= 1'b1;
                m_exp  <= model(op_code, op_a, op_b, p_c, p_d);
                m_cnt  <= model(op_code, op_a, op_b, p_c, p_d).adj ? 2 : 1;
            end
        end else if (!m_valid) begin
            if (m_cnt == 1) m_valid <= 1'b1;
            m_cnt <= m_cnt - 1;
        end else if (res_ready) begin
            m_valid <= 1'b0;
            m_busy  <= 1'b0;
        end
    end

    wire [4:0] sels = {alu_sum_sel, alu_and_sel, alu_xor_sel, alu_or_sel, alu_shr_sel};

    always @(negedge clk) begin
        chk("op_ready", op_ready, !m_busy);
        chk("res_valid", res_valid, m_valid);
        chk("sel_onehot", $countones(sels) <= 1, 1);
        if (!m_busy) chk("sel_idle", sels, 0);
        if (m_valid) begin
            chk("res_data", res_data, m_exp.data);
            chk("res_nzcv", {res_n, res_z, res_c, res_v}, {m_exp.n, m_exp.z, m_exp.c, m_exp.v});
            chk("res_we", {res_a_we, res_v_we}, {m_exp.awe, m_exp.vwe});
        end
    end

    task automatic do_op(input logic [2:0] op, input logic [7:0] a, b, input logic c, d,
                         input logic [7:0] e_data, input logic [3:0] e_nzcv,
                         input logic [1:0] e_we, input int e_lat, input int hold);
        int n;
        @(negedge clk);
        op_valid = 1'b1; op_code = op; op_a = a; op_b = b; p_c = c; p_d = d;
        @(posedge clk); #1;
        op_valid = 1'b0;
        op_a = ~a; op_b = ~b; p_c = ~c;
        n = 1;
        while (!res_valid && n < 10) begin
            @(posedge clk); #1;
            n++;
        end
        chk("latency", n, e_lat);
        chk("lit_data", res_data, e_data);
        chk("lit_nzcv", {res_n, res_z, res_c, res_v}, e_nzcv);
        chk("lit_we", {res_a_we, res_v_we}, e_we);
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            op_valid = ~op_valid;
            op_code = 3'd2;
            #1;
            chk("bp_op_ready", op_ready, 0);
            chk("bp_res_data", res_data, e_data);
        end
        if (hold > 0) @(negedge clk);
        op_valid = 1'b0;
        res_ready = 1'b1;
        @(posedge clk); #1;
        res_ready = 1'b0;
    endtask

    initial begin
        rst_n = 1'b0; op_valid = 1'b0; op_code = 3'd0; op_a = 8'h00; op_b = 8'h00;
        p_c = 1'b0; p_d = 1'b0; res_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_op_ready", op_ready, 1);
        chk("rst_res_valid", res_valid, 0);
        chk("rst_alu", {alu_a, alu_b, sels, alu_carry_in}, 0);
        chk("rst_res", {res_data, res_n, res_z, res_c, res_v, res_a_we, res_v_we}, 0);
        @(negedge clk) rst_n = 1'b1;

        //    op     a      b      C     D     data   NZCV     we     lat hold
        do_op(3'd0, 8'h50, 8'h50, 1'b0, 1'b0, 8'hA0, 4'b1001, 2'b11, 2, 0);
        do_op(3'd1, 8'h00, 8'h01, 1'b1, 1'b0, 8'hFF, 4'b1000, 2'b11, 2, 0);
        do_op(3'd7, 8'h42, 8'h42, 1'b0, 1'b0, 8'h00, 4'b0110, 2'b00, 2, 0);
        do_op(3'd6, 8'h01, 8'h00, 1'b1, 1'b0, 8'h80, 4'b1010, 2'b10, 2, 0);
        do_op(3'd5, 8'h01, 8'h00, 1'b0, 1'b0, 8'h00, 4'b0110, 2'b10, 2, 0);
        do_op(3'd2, 8'hF0, 8'h3C, 1'b0, 1'b0, 8'h30, 4'b0000, 2'b10, 2, 0);
        do_op(3'd3, 8'h0F, 8'hF0, 1'b1, 1'b0, 8'hFF, 4'b1010, 2'b10, 2, 0);
        do_op(3'd4, 8'hAA, 8'hAA, 1'b0, 1'b0, 8'h00, 4'b0100, 2'b10, 2, 0);
        do_op(3'd0, 8'hFF, 8'h01, 1'b0, 1'b0, 8'h00, 4'b0110, 2'b11, 2, 0);
        do_op(3'd0, 8'h7F, 8'h00, 1'b1, 1'b0, 8'h80, 4'b1001, 2'b11, 2, 0);
        do_op(3'd0, 8'h50, 8'h50, 1'b0, 1'b0, 8'hA0, 4'b1001, 2'b11, 2, 5);
`ifdef DECIMAL_MODE_EN
        do_op(3'd0, 8'h58, 8'h46, 1'b0, 1'b1, 8'h04, 4'b1011, 2'b11, 3, 0);
        do_op(3'd1, 8'h40, 8'h01, 1'b1, 1'b1, 8'h39, 4'b0010, 2'b11, 3, 0);
        do_op(3'd7, 8'h10, 8'h20, 1'b0, 1'b1, 8'hF0, 4'b1000, 2'b00, 2, 0);
`else
        do_op(3'd0, 8'h58, 8'h46, 1'b0, 1'b1, 8'h9E, 4'b1001, 2'b11, 2, 0);
        do_op(3'd1, 8'h40, 8'h01, 1'b1, 1'b1, 8'h3F, 4'b0010, 2'b11, 2, 0);
`endif

        // Reset during EXEC drops the op.
        @(negedge clk);
        op_valid = 1'b1; op_code = 3'd0; op_a = 8'h11; op_b = 8'h22; p_c = 1'b0; p_d = 1'b0;
        @(posedge clk); #1;
        op_valid = 1'b0;
        chk("exec_sum_sel", alu_sum_sel, 1);
        #1 rst_n = 1'b0;
        #1;
        chk("rst_mid_valid", res_valid, 0);
        chk("rst_mid_sel", sels, 0);
        chk("rst_mid_ready", op_ready, 1);
        @(negedge clk) rst_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk); #1;
            chk("rst_no_stale", res_valid, 0);
        end
        do_op(3'd2, 8'hF0, 8'h3C, 1'b1, 1'b0, 8'h30, 4'b0010, 2'b10, 2, 0);

        repeat (3) @(posedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
